// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
//
// Shares one registered-output block RAM read port between the CPU and the
// rectangle-copy controller. One read is granted per cycle at most. Read
// data comes back one cycle after the grant, and the requester that owns it
// is marked by its rvalid pulse.
//
// Priority within a cycle:
//   1. A CPU that has waited MAX_WAIT cycles is granted (starvation guard).
//   2. Copy, while copy_lock is held and copy_req is high.
//   3. Round-robin. A sole requester wins. On a tie, the requester that was
//      not granted most recently wins.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/cpu_addr/cpu_gnt       CPU read request, address, grant (comb)
//   cpu_rvalid/cpu_rdata           CPU read data and its qualifier
//   copy_req/copy_addr/copy_gnt    copy read request, address, grant (comb)
//   copy_lock                      copy burst in progress (raises copy priority)
//   copy_rvalid/copy_rdata         copy read data and its qualifier
//   mem_dout_addr                  RAM read address (last granted address when idle)
//   mem_dout                       RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int DATA_WIDTH = 13,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [15:0]           cpu_rdata,
    input  logic                  copy_req,
    input  logic [DATA_WIDTH-1:0] copy_addr,
    input  logic                  copy_lock,
    output logic                  copy_gnt,
    output logic                  copy_rvalid,
    output logic [15:0]           copy_rdata,
    output logic [DATA_WIDTH-1:0] mem_dout_addr,
    input  logic [15:0]           mem_dout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    // last_grant_copy_q: 1 = copy was granted most recently, 0 = CPU.
    logic                  last_grant_copy_q, last_grant_copy_d;
    logic [7:0]            wait_cnt_q,        wait_cnt_d;
    logic [DATA_WIDTH-1:0] last_addr_q,       last_addr_d;
    logic                  cpu_rvalid_q,      cpu_rvalid_d;
    logic                  copy_rvalid_q,     copy_rvalid_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= WAIT_LIMIT) ? WAIT_LIMIT : v + 8'd1;
    endfunction

    // Grant decision. Reset blocks every grant, even when requests are high.
    always_comb begin
        cpu_gnt  = 1'b0;
        copy_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (wait_cnt_q == WAIT_LIMIT)) begin
                cpu_gnt = 1'b1;
            end else if (copy_lock && copy_req) begin
                copy_gnt = 1'b1;
            end else if (cpu_req && copy_req) begin
                if (last_grant_copy_q) cpu_gnt  = 1'b1;
                else                   copy_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (copy_req) begin
                copy_gnt = 1'b1;
            end
        end
    end

    // Next-state values for the arbitration state and the read-return flags.
    always_comb begin
        last_grant_copy_d = last_grant_copy_q;
        last_addr_d       = last_addr_q;
        if (cpu_gnt) begin
            last_grant_copy_d = 1'b0;
            last_addr_d       = cpu_addr;
        end else if (copy_gnt) begin
            last_grant_copy_d = 1'b1;
            last_addr_d       = copy_addr;
        end

        if (cpu_req && !cpu_gnt) wait_cnt_d = sat_inc(wait_cnt_q);
        else                     wait_cnt_d = 8'd0;

        cpu_rvalid_d  = cpu_gnt;
        copy_rvalid_d = copy_gnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_copy_q <= 1'b0;
            wait_cnt_q        <= 8'd0;
            last_addr_q       <= '0;
            cpu_rvalid_q      <= 1'b0;
            copy_rvalid_q     <= 1'b0;
        end else begin
            last_grant_copy_q <= last_grant_copy_d;
            wait_cnt_q        <= wait_cnt_d;
            last_addr_q       <= last_addr_d;
            cpu_rvalid_q      <= cpu_rvalid_d;
            copy_rvalid_q     <= copy_rvalid_d;
        end
    end

    // The address is driven straight through in a grant cycle. Otherwise it
    // holds the last granted address, so the RAM output stays stable.
    assign mem_dout_addr = cpu_gnt  ? cpu_addr  :
                           copy_gnt ? copy_addr : last_addr_q;

    // Reset takes priority over rvalid. If reset arrives in the cycle after a
    // grant, it hides the pulse that the flop would otherwise present.
    assign cpu_rvalid  = cpu_rvalid_q  & ~reset;
    assign copy_rvalid = copy_rvalid_q & ~reset;

    assign cpu_rdata   = mem_dout;
    assign copy_rdata  = mem_dout;

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 13: data-memory word address width.
REQ-002 Parameter MAX_WAIT, default 8: CPU starvation limit in cycles; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU read request; held with cpu_addr stable until granted.
REQ-006 cpu_addr  input  DATA_WIDTH  CPU read address.
REQ-007 cpu_gnt  output  1  CPU request accepted this cycle (combinational).
REQ-008 cpu_rvalid  output  1  CPU read data valid on cpu_rdata.
REQ-009 cpu_rdata  output  16  CPU read data.
REQ-010 copy_req  input  1  rectangle-copy controller read request; same hold rule as CPU.
REQ-011 copy_addr  input  DATA_WIDTH  copy controller read address.
REQ-012 copy_lock  input  1  copy burst in progress; copy requests take priority.
REQ-013 copy_gnt  output  1  copy request accepted this cycle (combinational).
REQ-014 copy_rvalid  output  1  copy read data valid on copy_rdata.
REQ-015 copy_rdata  output  16  copy read data.
REQ-016 mem_dout_addr  output  DATA_WIDTH  bsram read address.
REQ-017 mem_dout  input  16  bsram read data, registered: valid one cycle after address.

Function
REQ-018 At most one grant per cycle; a grant occurs only when the corresponding req is high.
REQ-019 Priority order per cycle: (1) forced CPU grant when cpu_req and wait_cnt == MAX_WAIT; (2) copy when copy_lock and copy_req; (3) round-robin.
REQ-020 Round-robin: sole requester is granted; if both request, the requester not recorded in last_grant wins.
REQ-021 last_grant register updates to the granted requester on every grant, including forced and lock grants; holds otherwise.
REQ-022 wait_cnt: increments (saturating at MAX_WAIT) each cycle cpu_req is high and cpu_gnt low; clears to 0 when cpu_gnt high or cpu_req low.
REQ-023 mem_dout_addr equals the granted requester's address in a grant cycle; otherwise holds the last granted address (last_addr register).
REQ-024 Read latency exactly 1 cycle: grant in cycle N -> corresponding rvalid high in cycle N+1 only, single-cycle pulse per grant.
REQ-025 cpu_rdata and copy_rdata both equal mem_dout combinationally; only rvalid qualifies ownership.
REQ-026 Back-to-back grants allowed every cycle, including alternating requesters; throughput one read per cycle.
REQ-027 Request dropped before grant: no grant, no rvalid, wait_cnt clears.
REQ-028 copy_lock without copy_req: rule (2) inactive; CPU may be granted via round-robin.

Reset
REQ-029 During reset: cpu_gnt = copy_gnt = 0 regardless of requests; no grant recorded.
REQ-030 After reset: last_grant = CPU (copy wins first tie), wait_cnt = 0, last_addr = 0, cpu_rvalid = copy_rvalid = 0.
REQ-031 Reset asserted in the cycle after a grant suppresses that grant's rvalid (rvalid registers are reset-dominant).

Verification
REQ-032 Post-reset both req high, lock low, addrs 0x010/0x020 -> cycle 0 copy_gnt, mem_dout_addr 0x020; cycle 1 cpu_gnt, addr 0x010; copy_rvalid at cycle 1, cpu_rvalid at cycle 2; alternation continues.
REQ-033 copy_lock=1, copy_req=1 continuous, cpu_req=1, MAX_WAIT=8 -> copy granted 8 consecutive cycles, cpu_gnt forced on 9th cycle, wait_cnt returns to 0, copy granted next.
REQ-034 Only cpu_req pulsed at addr 0x1FFF, memory holding 0xBEEF -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xBEEF next cycle, copy_rvalid stays 0.
REQ-035 Idle after grant to 0x0123 -> mem_dout_addr stays 0x0123, no rvalid pulses.
REQ-036 Grant in cycle N, reset high in cycle N+1 -> no rvalid in N+1; after reset, tie goes to copy.
